// File: rtl/operand_packer.sv
// operand_packer
//   Assembles a narrow element/scale beat stream into one NUM_ELEM-element
//   operand vector plus NUM_ELEM/2 micro-scales, using a two-entry ping-pong
//   buffer so one vector can fill while the previous one waits downstream.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input beat handshake
//   in_elems              BEAT_ELEMS elements of the current beat
//   in_scales             BEAT_ELEMS/2 micro-scales of the current beat
//   in_mode               scale_sharing_mode, sampled on beat 0 only
//   in_last               final beat of the vector (may arrive early)
//   out_valid/out_ready   output vector handshake
//   out_elems             element i at [i*ELEM_W +: ELEM_W]
//   out_scales            lane l at [l*SCALE_W +: SCALE_W]
//   out_mode              latched scale_sharing_mode
//
// Optional build macro OPERAND_PACKER_STATS_EN adds:
//   stat_vectors          count of output handshakes (wraps at 2^32)
//   stat_padded           count of vectors completed early by in_last
module operand_packer #(
  parameter int NUM_ELEM   = 32,
  parameter int ELEM_W     = 8,
  parameter int BEAT_ELEMS = 4,
  parameter int SCALE_W    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BEAT_ELEMS*ELEM_W-1:0]       in_elems,
  input  logic [(BEAT_ELEMS/2)*SCALE_W-1:0]  in_scales,
  input  logic                               in_mode,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_ELEM*ELEM_W-1:0]         out_elems,
  output logic [(NUM_ELEM/2)*SCALE_W-1:0]    out_scales,
  output logic                               out_mode
`ifdef OPERAND_PACKER_STATS_EN
  ,
  output logic [31:0]                        stat_vectors,
  output logic [31:0]                        stat_padded
`endif
);

  localparam int NUM_BEATS = NUM_ELEM / BEAT_ELEMS;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int EVEC_W    = NUM_ELEM * ELEM_W;
  localparam int SVEC_W    = (NUM_ELEM / 2) * SCALE_W;
  localparam int BEAT_EW   = BEAT_ELEMS * ELEM_W;
  localparam int BEAT_SW   = (BEAT_ELEMS / 2) * SCALE_W;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  buf_state_e              state_q  [2];
  buf_state_e              state_d  [2];
  logic [EVEC_W-1:0]       elems_q  [2];
  logic [EVEC_W-1:0]       elems_d  [2];
  logic [SVEC_W-1:0]       scales_q [2];
  logic [SVEC_W-1:0]       scales_d [2];
  logic                    mode_q   [2];
  logic                    mode_d   [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;

  logic                    beat_acc;
  logic                    natural_end;
  logic                    vec_done;
  logic                    out_hs;
  int unsigned             elem_off;
  int unsigned             scale_off;

  // Ready depends only on registered state (plus reset), never on in_valid.
  assign in_ready    = !rst && (state_q[wr_ptr_q] != BUF_FULL);
  assign beat_acc    = in_valid && in_ready;
  assign natural_end = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));
  assign vec_done    = beat_acc && (natural_end || in_last);

  assign out_valid   = (state_q[rd_ptr_q] == BUF_FULL);
  assign out_hs      = out_valid && out_ready;
  assign out_elems   = elems_q[rd_ptr_q];
  assign out_scales  = scales_q[rd_ptr_q];
  assign out_mode    = mode_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    elems_d    = elems_q;
    scales_d   = scales_q;
    mode_d     = mode_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    elem_off   = 32'(beat_cnt_q) * BEAT_EW;
    scale_off  = 32'(beat_cnt_q) * BEAT_SW;

    if (beat_acc) begin
      // Clearing the whole entry on beat 0 makes slots skipped by an early
      // in_last read back as zero without any per-slot valid tracking.
      if (beat_cnt_q == '0) begin
        elems_d[wr_ptr_q]  = '0;
        scales_d[wr_ptr_q] = '0;
        mode_d[wr_ptr_q]   = in_mode;
        state_d[wr_ptr_q]  = BUF_FILLING;
      end
      elems_d[wr_ptr_q][elem_off +: BEAT_EW]   = in_elems;
      scales_d[wr_ptr_q][scale_off +: BEAT_SW] = in_scales;

      if (vec_done) begin
        state_d[wr_ptr_q] = BUF_FULL;
        wr_ptr_d          = ~wr_ptr_q;
        beat_cnt_d        = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    // A completing entry is FILLING and a draining entry is FULL, so both
    // updates in one cycle always target different entries.
    if (out_hs) begin
      state_d[rd_ptr_q] = BUF_EMPTY;
      rd_ptr_d          = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        state_q[b]  <= BUF_EMPTY;
        elems_q[b]  <= '0;
        scales_q[b] <= '0;
        mode_q[b]   <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      elems_q    <= elems_d;
      scales_q   <= scales_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef OPERAND_PACKER_STATS_EN
  logic [31:0] stat_vectors_q, stat_vectors_d;
  logic [31:0] stat_padded_q, stat_padded_d;

  always_comb begin
    stat_vectors_d = stat_vectors_q;
    stat_padded_d  = stat_padded_q;
    if (out_hs) begin
      stat_vectors_d = stat_vectors_q + 32'd1;
    end
    // Padded means in_last ended the vector before its natural final beat.
    if (vec_done && !natural_end) begin
      stat_padded_d = stat_padded_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_vectors_q <= '0;
      stat_padded_q  <= '0;
    end else begin
      stat_vectors_q <= stat_vectors_d;
      stat_padded_q  <= stat_padded_d;
    end
  end

  assign stat_vectors = stat_vectors_q;
  assign stat_padded  = stat_padded_q;
`endif

endmodule

// File: tb/tb_operand_packer.sv
// tb_operand_packer
//   Scoreboard bench for operand_packer: each scenario task pushes the
//   expected vector when it drives the stimulus; a negedge monitor pops and
//   compares on every output handshake.
module tb_operand_packer;

  localparam int NUM_ELEM   = 32;
  localparam int ELEM_W     = 8;
  localparam int BEAT_ELEMS = 4;
  localparam int SCALE_W    = 8;
  localparam int NB  = NUM_ELEM / BEAT_ELEMS;
  localparam int EW  = NUM_ELEM * ELEM_W;
  localparam int SW  = (NUM_ELEM / 2) * SCALE_W;
  localparam int BW  = BEAT_ELEMS * ELEM_W;
  localparam int BSW = (BEAT_ELEMS / 2) * SCALE_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_elems;
  logic [BSW-1:0] in_scales;
  logic          in_mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_elems;
  logic [SW-1:0] out_scales;
  logic          out_mode;
`ifdef OPERAND_PACKER_STATS_EN
  logic [31:0]   stat_vectors;
  logic [31:0]   stat_padded;
`endif

  operand_packer #(
    .NUM_ELEM  (NUM_ELEM),
    .ELEM_W    (ELEM_W),
    .BEAT_ELEMS(BEAT_ELEMS),
    .SCALE_W   (SCALE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_elems  (in_elems),
    .in_scales (in_scales),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_elems (out_elems),
    .out_scales(out_scales),
    .out_mode  (out_mode)
`ifdef OPERAND_PACKER_STATS_EN
    ,
    .stat_vectors(stat_vectors),
    .stat_padded (stat_padded)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [EW-1:0] e;
    logic [SW-1:0] s;
    logic          m;
  } vec_t;

  vec_t sb[$];
  vec_t mon_exp;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pops = 0;
  int   pops_rst = 0;
  int   pop_cyc[$];
  int   stalls = 0;
  int   exp_padded = 0;

  // Scoreboard monitor: a handshake happens at the next posedge when both
  // valid and ready are seen here.
  always @(negedge clk) begin
    if (rst) begin
      pops_rst = 0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: handshake with empty scoreboard, elems=%h", out_elems);
      end else begin
        mon_exp = sb.pop_front();
        checks++;
        if (out_elems !== mon_exp.e) begin
          errors++;
          $display("FAIL sb_elems: got=%h exp=%h", out_elems, mon_exp.e);
        end
        checks++;
        if (out_scales !== mon_exp.s) begin
          errors++;
          $display("FAIL sb_scales: got=%h exp=%h", out_scales, mon_exp.s);
        end
        checks++;
        if (out_mode !== mon_exp.m) begin
          errors++;
          $display("FAIL sb_mode: got=%b exp=%b", out_mode, mon_exp.m);
        end
      end
      pops++;
      pops_rst++;
      pop_cyc.push_back(cyc);
    end
    cyc++;
  end

  function automatic logic [EW-1:0] rand_e();
    logic [EW-1:0] r;
    for (int i = 0; i < EW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_s();
    logic [SW-1:0] r;
    for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Drives nb beats of a vector; entered and left at posedge+1.
  task automatic send_vec(input logic [EW-1:0] ve, input logic [SW-1:0] vs,
                          input logic [NB-1:0] vm, input int nb,
                          input bit last_flag, input bit push);
    vec_t x;
    int   budget;
    x.e = '0;
    x.s = '0;
    for (int i = 0; i < nb * BEAT_ELEMS; i++) x.e[i*ELEM_W +: ELEM_W] = ve[i*ELEM_W +: ELEM_W];
    for (int l = 0; l < nb * (BEAT_ELEMS / 2); l++) x.s[l*SCALE_W +: SCALE_W] = vs[l*SCALE_W +: SCALE_W];
    x.m = vm[0];
    if (push) sb.push_back(x);
    for (int b = 0; b < nb; b++) begin
      in_valid  = 1'b1;
      in_elems  = ve[b*BW +: BW];
      in_scales = vs[b*BSW +: BSW];
      in_mode   = vm[b];
      in_last   = last_flag && (b == nb - 1);
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 200) begin
        stalls++; budget++;
        @(negedge clk);
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL beat_accept_timeout: in_ready=%b required=1 at beat %0d", in_ready, b);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (last_flag && nb < NB) exp_padded++;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mode  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_elems = '0; in_scales = '0;
    in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got=%b exp=0", in_ready); end
    checks++; if (out_elems !== '0) begin errors++; $display("FAIL rst_out_elems: got=%h exp=0", out_elems); end
    checks++; if (out_scales !== '0) begin errors++; $display("FAIL rst_out_scales: got=%h exp=0", out_scales); end
    checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL rst_out_mode: got=%b exp=0", out_mode); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_vector();
    logic [EW-1:0] ve;
    logic [SW-1:0] vs;
    int budget;
    for (int i = 0; i < NUM_ELEM; i++) ve[i*ELEM_W +: ELEM_W] = 8'(i);
    for (int l = 0; l < NUM_ELEM / 2; l++) vs[l*SCALE_W +: SCALE_W] = 8'(l % 4);
    out_ready = 1'b1;
    send_vec(ve, vs, '0, NB, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency_valid: got=%b exp=1", out_valid); end
    checks++; if (out_elems[17*ELEM_W +: ELEM_W] !== 8'h11) begin errors++; $display("FAIL full_elem17: got=%h exp=11", out_elems[17*ELEM_W +: ELEM_W]); end
    checks++; if (out_scales[9*SCALE_W +: SCALE_W] !== 8'h01) begin errors++; $display("FAIL full_lane9: got=%h exp=01", out_scales[9*SCALE_W +: SCALE_W]); end
    checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL full_mode: got=%b exp=0", out_mode); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pulse: got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_drain: pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_mode_latch();
    int budget;
    out_ready = 1'b1;
    send_vec(rand_e(), rand_s(), 8'b0000_0001, NB, 1'b0, 1'b1);
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 20) begin budget++; @(negedge clk); end
    checks++; if (out_valid !== 1'b1 || out_mode !== 1'b1) begin errors++; $display("FAIL mode_latch: valid=%b mode=%b exp valid=1 mode=1", out_valid, out_mode); end
    @(posedge clk); #1;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mode_drain: pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_early_last();
    logic [EW-1:0] ve;
    logic [SW-1:0] vs;
    int budget;
    ve = rand_e();
    vs = rand_s();
    for (int i = 0; i < 12; i++) ve[i*ELEM_W +: ELEM_W] = 8'(8'h81 + i);
    for (int l = 0; l < 6; l++) vs[l*SCALE_W +: SCALE_W] = 8'(8'hC0 + l);
    out_ready = 1'b1;
    send_vec(ve, vs, '0, 3, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL early_valid: got=%b exp=1", out_valid); end
    checks++; if (out_elems[EW-1:12*ELEM_W] !== '0) begin errors++; $display("FAIL early_pad_elems: got=%h exp=0", out_elems[EW-1:12*ELEM_W]); end
    checks++; if (out_scales[SW-1:6*SCALE_W] !== '0) begin errors++; $display("FAIL early_pad_scales: got=%h exp=0", out_scales[SW-1:6*SCALE_W]); end
    checks++; if (out_elems[11*ELEM_W +: ELEM_W] !== 8'h8C) begin errors++; $display("FAIL early_elem11: got=%h exp=8c", out_elems[11*ELEM_W +: ELEM_W]); end
    @(posedge clk); #1;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL early_drain: pending=%0d exp=0", sb.size()); end
`ifdef OPERAND_PACKER_STATS_EN
    checks++; if (stat_padded !== 32'(exp_padded)) begin errors++; $display("FAIL early_stat_padded: got=%0d exp=%0d", stat_padded, exp_padded); end
`endif
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] snap_e;
    logic [SW-1:0] snap_s;
    bit stable;
    int p0;
    int budget;
    out_ready = 1'b0;
    send_vec(rand_e(), rand_s(), '0, NB, 1'b0, 1'b1);
    send_vec(rand_e(), rand_s(), '0, NB, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got=%b exp=0", in_ready); end
    snap_e = out_elems;
    snap_s = out_scales;
    // Garbage offered while both entries are full must be ignored.
    @(posedge clk); #1;
    in_valid = 1'b1; in_elems = '1; in_scales = '1; in_mode = 1'b1; in_last = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_elems !== snap_e || out_scales !== snap_s || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_stall_stable: stable=%b exp=1 elems=%h", stable, out_elems); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0;
    p0 = pops;
    out_ready = 1'b1;
    send_vec(rand_e(), rand_s(), '0, NB, 1'b0, 1'b1);
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: pending=%0d exp=0", sb.size()); end
    checks++;
    if (pops - p0 != 3) begin
      errors++; $display("FAIL bp_count: got=%0d exp=3", pops - p0);
    end else if (pop_cyc[p0+1] - pop_cyc[p0] != 1) begin
      errors++; $display("FAIL bp_back_to_back: gap=%0d exp=1", pop_cyc[p0+1] - pop_cyc[p0]);
    end
  endtask

  task automatic test_reset_mid_fill();
    int budget;
    out_ready = 1'b0;
    send_vec(rand_e(), rand_s(), '0, NB, 1'b0, 1'b0);
    send_vec(rand_e(), rand_s(), '1, 5, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmf_pre_valid: got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_out_valid: got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmf_in_ready: got=%b exp=0", in_ready); end
    checks++; if (out_elems !== '0) begin errors++; $display("FAIL rmf_out_elems: got=%h exp=0", out_elems); end
    exp_padded = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_vec(rand_e(), rand_s(), '0, NB, 1'b0, 1'b1);
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmf_drain: pending=%0d exp=0", sb.size()); end
    checks++; if (pops_rst != 1) begin errors++; $display("FAIL rmf_count: got=%0d exp=1", pops_rst); end
  endtask

  task automatic test_throughput();
    int p0;
    int s0;
    int budget;
    out_ready = 1'b1;
    p0 = pops;
    s0 = stalls;
    // in_last on the natural final beat of vector 3 must be harmless.
    for (int k = 0; k < 8; k++) send_vec(rand_e(), rand_s(), NB'($urandom()), NB, (k == 3), 1'b1);
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL tp_drain: pending=%0d exp=0", sb.size()); end
    checks++; if (pops - p0 != 8) begin errors++; $display("FAIL tp_count: got=%0d exp=8", pops - p0); end
    checks++; if (stalls != s0) begin errors++; $display("FAIL tp_in_ready_drop: stall_cycles=%0d exp=0", stalls - s0); end
`ifdef OPERAND_PACKER_STATS_EN
    checks++; if (stat_vectors !== 32'(pops_rst)) begin errors++; $display("FAIL tp_stat_vectors: got=%0d exp=%0d", stat_vectors, pops_rst); end
    checks++; if (stat_padded !== 32'(exp_padded)) begin errors++; $display("FAIL tp_stat_padded: got=%0d exp=%0d", stat_padded, exp_padded); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_mode_latch();
    test_early_last();
    test_backpressure();
    test_reset_mid_fill();
    test_throughput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
